// File: rtl/channel_ctl_pkg.sv
// Shared types and width helpers for the channel coefficient sequencer.
// The *_W constants describe the default configuration.
package channel_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_NPROF  = 4;
    localparam int DEF_NCOEF  = 8;
    localparam int DEF_CW     = 16;
    localparam int DEF_SETTLE = 32;

    // A field must be at least one bit wide, even for a single-entry range.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int clamp_prof(input int p, input int nprof);
        return (p >= nprof) ? nprof - 1 : p;
    endfunction

    localparam int PROF_W = width_of(DEF_NPROF);
    localparam int IDX_W  = width_of(DEF_NCOEF);
    localparam int ADDR_W = width_of(DEF_NPROF * DEF_NCOEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
    import channel_ctl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int PTR_W = width_of(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_cfg_sequencer.sv
// Arbitrates requesters onto the channel coefficient port and streams one
// profile per grant, followed by commit, settle wait and a done pulse.
module channel_cfg_sequencer
    import channel_ctl_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int NPROF  = DEF_NPROF,
    parameter int NCOEF  = DEF_NCOEF,
    parameter int CW     = DEF_CW,
    parameter int SETTLE = DEF_SETTLE,
    localparam int PROF_BITS = width_of(NPROF),
    localparam int IDX_BITS  = width_of(NCOEF),
    localparam int ADDR_BITS = width_of(NPROF * NCOEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*PROF_BITS-1:0] req_prof,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    input  logic                      tbl_we,
    input  logic [ADDR_BITS-1:0]      tbl_addr,
    input  logic [CW-1:0]             tbl_wdata,
    output logic                      tbl_err,
    output logic                      cf_valid,
    input  logic                      cf_ready,
    output logic [IDX_BITS-1:0]       cf_idx,
    output logic [CW-1:0]             cf_data,
    output logic                      cf_commit,
    output logic                      busy
);

    localparam int PTR_W = width_of(NREQ);
    localparam int CNT_W = width_of(SETTLE);

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [NREQ-1:0]      done_q, done_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PROF_BITS-1:0] prof_q, prof_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [CW-1:0]        data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 commit_q, commit_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [CW-1:0]        tbl_mem [NPROF*NCOEF];

    logic [NREQ-1:0]      win_onehot;
    logic [PTR_W-1:0]     win_idx;
    logic [PROF_BITS-1:0] win_prof;
    logic [PROF_BITS-1:0] addr_prof;
    logic                 protect;

    function automatic logic [ADDR_BITS-1:0] tbl_index(input logic [PROF_BITS-1:0] p,
                                                      input logic [IDX_BITS-1:0] i);
        return ADDR_BITS'(32'(p) * NCOEF + 32'(i));
    endfunction

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (win_onehot),
        .idx (win_idx)
    );

    assign win_prof  = PROF_BITS'(clamp_prof(int'(req_prof[win_idx*PROF_BITS +: PROF_BITS]), NPROF));
    assign addr_prof = PROF_BITS'(32'(tbl_addr) / NCOEF);

    // The profile being streamed stays frozen until the transaction has settled.
    assign protect = (state_q inside {ST_LOAD, ST_COMMIT, ST_SETTLE}) && (addr_prof == prof_q);
    assign err_d   = tbl_we && protect;

    // Table storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (tbl_we && !protect) begin
            tbl_mem[tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            ptr_q    <= '0;
            prof_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            ptr_q    <= ptr_d;
            prof_q   <= prof_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        ptr_d    = ptr_q;
        prof_d   = prof_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        commit_d = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_LOAD;
                    gnt_d   = win_onehot;
                    prof_d  = win_prof;
                    ptr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = tbl_mem[tbl_index(win_prof, '0)];
                end
            end
            // Next coefficient is fetched on the accepting edge so transfers run back-to-back.
            ST_LOAD: begin
                if (valid_q && cf_ready) begin
                    if (idx_q == IDX_BITS'(NCOEF - 1)) begin
                        state_d  = ST_COMMIT;
                        valid_d  = 1'b0;
                        commit_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_BITS'(1);
                        data_d = tbl_mem[tbl_index(prof_q, idx_q + IDX_BITS'(1))];
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_SETTLE;
                cnt_d   = CNT_W'(SETTLE - 1);
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign tbl_err   = err_q;
    assign cf_valid  = valid_q;
    assign cf_idx    = idx_q;
    assign cf_data   = data_q;
    assign cf_commit = commit_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_channel_cfg_sequencer.sv
// Bench for channel_cfg_sequencer: directed vector table, reset-in-flight
// sequence, and randomized transactions checked against a table/arbiter model.
module tb_channel_cfg_sequencer;
    import channel_ctl_pkg::*;

    localparam int NREQ   = DEF_NREQ;
    localparam int NPROF  = DEF_NPROF;
    localparam int NCOEF  = DEF_NCOEF;
    localparam int CW     = DEF_CW;
    localparam int SETTLE = DEF_SETTLE;
    localparam int RPW    = NREQ * PROF_W;
    localparam int BUDGET = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [RPW-1:0]    req_prof;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_addr;
    logic [CW-1:0]     tbl_wdata;
    logic              tbl_err;
    logic              cf_valid;
    logic              cf_ready;
    logic [IDX_W-1:0]  cf_idx;
    logic [CW-1:0]     cf_data;
    logic              cf_commit;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] model_tbl [NPROF][NCOEF];
    int            model_ptr = 0;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [RPW-1:0]  rp;
        int              mode;
        bit              hold;
        int              wr_prof;
        logic [NREQ-1:0] exp_gnt;
        int              exp_prof;
    } vec_t;

    vec_t vecs [10];

    channel_cfg_sequencer #(
        .NREQ(NREQ), .NPROF(NPROF), .NCOEF(NCOEF), .CW(CW), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_prof(req_prof), .gnt(gnt), .done(done),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_err(tbl_err),
        .cf_valid(cf_valid), .cf_ready(cf_ready), .cf_idx(cf_idx), .cf_data(cf_data),
        .cf_commit(cf_commit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RPW-1:0] pack2(input int p0, input int p1);
        return {PROF_W'(p1), PROF_W'(p0)};
    endfunction

    function automatic vec_t mkv(input logic [NREQ-1:0] r, input logic [RPW-1:0] rp, input int mode,
                                 input bit hold, input int wp, input logic [NREQ-1:0] g, input int p);
        vec_t v;
        v.req = r; v.rp = rp; v.mode = mode; v.hold = hold;
        v.wr_prof = wp; v.exp_gnt = g; v.exp_prof = p;
        return v;
    endfunction

    // Winner is the requester with the smallest rotational distance from the pointer.
    function automatic int model_winner(input logic [NREQ-1:0] r);
        int best, best_d, d;
        best = 0;
        best_d = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - model_ptr + NREQ) % NREQ;
            if (r[i] && d < best_d) begin
                best_d = d;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic int clamp_p(input int p);
        return (p >= NPROF) ? NPROF - 1 : p;
    endfunction

    task automatic write_tbl(input int p, input int c, input logic [CW-1:0] v);
        tbl_we = 1'b1;
        tbl_addr = ADDR_W'(p * NCOEF + c);
        tbl_wdata = v;
        tick();
        tbl_we = 1'b0;
        checkOutput("idle_write_err", tbl_err, 0);
        model_tbl[p][c] = v;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_gnt"}, gnt, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_tbl_err"}, tbl_err, 0);
        checkOutput({tag, "_cf_valid"}, cf_valid, 0);
        checkOutput({tag, "_cf_idx"}, cf_idx, 0);
        checkOutput({tag, "_cf_data"}, cf_data, 0);
        checkOutput({tag, "_cf_commit"}, cf_commit, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    // One full transaction; mode 0 = ready high, 1 = ready toggling 1,0, 2 = random ready.
    task automatic applyStimulus(input logic [NREQ-1:0] req_v, input logic [RPW-1:0] rp,
                                 input int mode, input bit hold, input int wr_prof,
                                 input logic [NREQ-1:0] exp_gnt, input int exp_prof);
        int edges, nxfer, commit_edge, done_edge, ncommit, exp_win;
        bit done_seen, wr_pending, exp_err, wr_done, held;
        logic [IDX_W-1:0] held_idx;
        logic [CW-1:0] held_data, wv;
        exp_win = 0;
        for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) exp_win = i;
        req = req_v;
        req_prof = rp;
        cf_ready = 1'b0;
        tick();
        if (!hold) req = '0;
        checkOutput("grant", gnt, exp_gnt);
        checkOutput("busy_in_txn", busy, 1);
        checkOutput("first_idx", cf_idx, 0);
        model_ptr = (exp_win + 1) % NREQ;
        edges = 1; nxfer = 0; commit_edge = -1; done_edge = -1; ncommit = 0;
        done_seen = 0; wr_pending = 0; exp_err = 0; wr_done = 0; held = 0;
        held_idx = '0; held_data = '0;
        while (!done_seen && edges < BUDGET) begin
            if (held) begin
                checkOutput("hold_valid", cf_valid, 1);
                checkOutput("hold_idx", cf_idx, held_idx);
                checkOutput("hold_data", cf_data, held_data);
                held = 0;
            end
            if (wr_pending) begin
                tbl_we = 1'b0;
                checkOutput("load_write_err", tbl_err, exp_err);
                wr_pending = 0;
            end
            if (cf_commit === 1'b1) begin
                ncommit++;
                commit_edge = edges;
                checkOutput("commit_after_last", nxfer, NCOEF);
            end
            if (done !== '0) begin
                done_seen = 1;
                done_edge = edges;
                checkOutput("done_target", done, exp_gnt);
            end else begin
                checkOutput("gnt_held", gnt, exp_gnt);
                case (mode)
                    0: cf_ready = 1'b1;
                    1: cf_ready = (edges % 2) == 1;
                    default: cf_ready = 1'($urandom_range(0, 1));
                endcase
                if (cf_valid === 1'b1) begin
                    if (cf_ready) begin
                        checkOutput("xfer_idx", cf_idx, nxfer);
                        checkOutput("xfer_data", cf_data, model_tbl[exp_prof][nxfer % NCOEF]);
                        nxfer++;
                    end else begin
                        held = 1;
                        held_idx = cf_idx;
                        held_data = cf_data;
                    end
                end
                if (wr_prof >= 0 && !wr_done && nxfer == 3) begin
                    wv = ~model_tbl[wr_prof][5];
                    tbl_we = 1'b1;
                    tbl_addr = ADDR_W'(wr_prof * NCOEF + 5);
                    tbl_wdata = wv;
                    exp_err = (wr_prof == exp_prof);
                    if (!exp_err) model_tbl[wr_prof][5] = wv;
                    wr_pending = 1;
                    wr_done = 1;
                end
                tick();
                edges++;
            end
        end
        tbl_we = 1'b0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL txn_timeout: got no done within %0d cycles, expected done", BUDGET);
        end else begin
            checkOutput("xfer_count", nxfer, NCOEF);
            checkOutput("commit_count", ncommit, 1);
            checkOutput("settle_len", done_edge - commit_edge, SETTLE + 1);
            if (mode == 0) begin
                checkOutput("commit_edge", commit_edge, NCOEF + 1);
                checkOutput("done_edge", done_edge, NCOEF + SETTLE + 2);
            end
            cf_ready = 1'b0;
            tick();
            checkOutput("idle_gnt", gnt, 0);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_done", done, 0);
        end
    endtask

    initial begin
        int waited, commits, w, p, wp;
        logic [NREQ-1:0] rv;
        logic [RPW-1:0] rp;

        rst = 1'b1; req = '0; req_prof = '0; tbl_we = 1'b0; tbl_addr = '0;
        tbl_wdata = '0; cf_ready = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        for (int pi = 0; pi < NPROF; pi++)
            for (int ci = 0; ci < NCOEF; ci++)
                write_tbl(pi, ci, (pi == 1) ? CW'(ci + 1) : CW'($urandom));

        vecs[0] = mkv(2'b01, pack2(1, 0), 0, 0, -1, 2'b01, 1);
        vecs[1] = mkv(2'b01, pack2(1, 0), 1, 0, -1, 2'b01, 1);
        vecs[2] = mkv(2'b10, pack2(0, 2), 0, 0,  2, 2'b10, 2);
        vecs[3] = mkv(2'b01, pack2(2, 0), 2, 0,  3, 2'b01, 2);
        vecs[4] = mkv(2'b11, pack2(0, 3), 0, 1, -1, 2'b10, 3);
        vecs[5] = mkv(2'b11, pack2(0, 3), 0, 1, -1, 2'b01, 0);
        vecs[6] = mkv(2'b11, pack2(0, 3), 0, 1, -1, 2'b10, 3);
        vecs[7] = mkv(2'b11, pack2(0, 3), 0, 0, -1, 2'b01, 0);
        vecs[8] = mkv(2'b10, pack2(0, 3), 0, 0, -1, 2'b10, 3);
        vecs[9] = mkv(2'b11, pack2(1, 2), 1, 0, -1, 2'b01, 1);

        $display("[TB] directed vectors");
        for (int vi = 0; vi < 10; vi++)
            applyStimulus(vecs[vi].req, vecs[vi].rp, vecs[vi].mode, vecs[vi].hold,
                          vecs[vi].wr_prof, vecs[vi].exp_gnt, vecs[vi].exp_prof);

        $display("[TB] reset during load");
        req = 2'b01;
        req_prof = pack2(0, 0);
        cf_ready = 1'b1;
        tick();
        req = '0;
        checkOutput("rst_test_grant", gnt, 2'b01);
        waited = 0;
        while (!(cf_valid === 1'b1 && cf_idx === IDX_W'(4)) && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("rst_reached_idx4", 32'(waited < 20), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cf_ready = 1'b0;
        check_reset_values("mid_reset");
        model_ptr = 0;
        commits = 0;
        for (int i = 0; i < 60; i++) begin
            cf_ready = 1'b1;
            tick();
            if (cf_commit === 1'b1) commits++;
        end
        cf_ready = 1'b0;
        checkOutput("no_partial_commit", commits, 0);
        checkOutput("busy_after_rst", busy, 0);
        applyStimulus(2'b11, pack2(1, 2), 0, 0, -1, 2'b01, 1);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 12; t++) begin
            rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rp = RPW'($urandom);
            w = model_winner(rv);
            p = clamp_p(int'(rp[w*PROF_W +: PROF_W]));
            wp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NPROF - 1)) : -1;
            applyStimulus(rv, rp, 2, 1'($urandom_range(0, 1)), wp, NREQ'(1) << w, p);
        end
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
